// File: rtl/ila_reader_pkg.sv
// Shared definitions for the ILA capture-buffer readout engine.
// State encoding is fixed so software/debug views of the state register stay stable.
package ila_reader_pkg;

  // Readout FSM states; HEADER is only reachable when ILA_READER_HEADER_EN is defined.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StCapture = 3'd2,
    StSend    = 3'd3,
    StHeader  = 3'd4
  } ila_reader_state_e;

  // Cycles from an index change until ila_core presents the matching value.
  localparam int unsigned ReadLatency = 1;

  // Width of the counter that waits out the read latency in FETCH.
  localparam int unsigned LatW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

endpackage

// File: rtl/ila_reader.sv
// ILA capture-buffer readout engine: on start, walks index from 0 to samples-1 and streams
// each captured value out on a valid/ready byte stream, one beat per FETCH/CAPTURE/SEND pass.
// Optional: define ILA_READER_HEADER_EN to prepend a header beat carrying the sample count.
module ila_reader
  import ila_reader_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BUFFER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  input  logic [BUFFER_W-1:0] samples,
  output logic [BUFFER_W-1:0] index,
  input  logic [DATA_W-1:0]   value,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
);

  ila_reader_state_e   state_q;
  logic [BUFFER_W-1:0] index_q;
  logic [BUFFER_W-1:0] count_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                last_q;
  logic                done_q;
  logic [LatW-1:0]     lat_q;

  logic                is_last_idx;
  logic                fetch_ready;

  // Final index of the latched dump; count_q is never zero outside IDLE/HEADER.
  assign is_last_idx = (index_q == (count_q - BUFFER_W'(1)));
  // ila_core has presented value for index_q once the read latency has elapsed.
  assign fetch_ready = (lat_q == LatW'(ReadLatency - 1));

  // Readout FSM with all stream/handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      lat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != StIdle) && abort) begin
        // Abort wins over a simultaneous handshake: that beat is treated as undelivered.
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        done_q  <= 1'b1;
        lat_q   <= '0;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              count_q <= samples;
              index_q <= '0;
              lat_q   <= '0;
`ifdef ILA_READER_HEADER_EN
              // Header carries the latched count, resized to the stream word.
              data_q  <= DATA_W'(samples);
              valid_q <= 1'b1;
              last_q  <= (samples == '0);
              state_q <= StHeader;
`else
              if (samples != '0) begin
                state_q <= StFetch;
              end else begin
                done_q <= 1'b1;
              end
`endif
            end
          end

`ifdef ILA_READER_HEADER_EN
          StHeader: begin
            if (out_ready) begin
              valid_q <= 1'b0;
              if (last_q) begin
                last_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                index_q <= '0;
                lat_q   <= '0;
                state_q <= StFetch;
              end
            end
          end
`endif

          StFetch: begin
            if (fetch_ready) begin
              lat_q   <= '0;
              state_q <= StCapture;
            end else begin
              lat_q <= lat_q + LatW'(1);
            end
          end

          StCapture: begin
            data_q  <= value;
            valid_q <= 1'b1;
            last_q  <= is_last_idx;
            state_q <= StSend;
          end

          StSend: begin
            // Beat is held untouched until the sink accepts it.
            if (out_ready) begin
              valid_q <= 1'b0;
              if (last_q) begin
                last_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                index_q <= index_q + BUFFER_W'(1);
                lat_q   <= '0;
                state_q <= StFetch;
              end
            end
          end

          default: begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign index     = index_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifndef SYNTHESIS
  // A stalled beat must stay put unless the dump is aborted.
  a_stall_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !abort) |=> (out_valid && $stable(out_data) && $stable(out_last)));

  // out_last only ever qualifies a valid beat.
  a_last_valid : assert property (@(posedge clk) disable iff (rst)
    out_last |-> out_valid);

  // Reads never run past the latched count.
  a_index_range : assert property (@(posedge clk) disable iff (rst)
    (state_q inside {StFetch, StCapture, StSend}) |-> (index_q < count_q));
`endif

endmodule

// File: doc/ila_reader.md
Name: ila_reader

Overview:
- Readout engine for the ILA capture buffer: on `start`, walks `index` from 0 to `samples-1` and streams each captured `value` out on a valid/ready byte stream.
- Sits between `ila_core` (index/value/samples port) and a host transport such as a UART TX or a CPU FIFO.
- Owns the buffer read side, so software no longer polls `index` one sample at a time.

Parameters:
- DATA_W, 8, width of one captured sample and of the output stream word.
- BUFFER_W, 8, index width; the buffer holds up to 2^BUFFER_W entries.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  terminate the dump in progress.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the last beat is accepted or the dump is aborted.
- samples  input  BUFFER_W  number of valid entries, from ila_core.
- index  output  BUFFER_W  buffer read address, to ila_core.
- value  input  DATA_W  buffer data, from ila_core; valid one clock after index changes.
- out_data  output  DATA_W  stream data.
- out_valid  output  1  stream valid.
- out_last  output  1  marks the final beat of a dump.
- out_ready  input  1  stream ready from the sink.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE.
  - index=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, count register=0.
- IDLE:
  - start=1 and samples>0: latch count=samples, index<=0, go FETCH.
  - start=1 and samples=0: pulse done next cycle, emit no beats, stay IDLE.
  - samples changing after start has no effect on the dump in progress.
- FETCH: one cycle; ila_core registers value for the current index. Go CAPTURE.
- CAPTURE:
  - out_data<=value, out_valid<=1.
  - out_last<=(index==count-1).
  - Go SEND.
- SEND:
  - Hold out_data/out_valid/out_last stable until out_ready=1; never drop valid without a handshake.
  - On out_valid&out_ready:
    - out_valid<=0.
    - If out_last: done<=1 for one cycle, go IDLE.
    - Else: index<=index+1, go FETCH.
- Latency and throughput:
  - First beat valid 3 cycles after the start edge.
  - With out_ready held high, one beat every 3 cycles.
- Wrap: samples=2^BUFFER_W-1 reads indices 0..2^BUFFER_W-2. index never wraps within a dump.
- start while busy: ignored.
- abort (any non-IDLE state):
  - Next cycle: out_valid=0, out_last=0, done pulse, IDLE.
  - abort takes priority over a simultaneous handshake; that beat counts as not delivered.
- Reset mid-dump: returns to IDLE with no done pulse; the sink must discard the partial dump.
- index after a completed dump: holds its last value.

Optional Feature:
- Macro: ILA_READER_HEADER_EN.
- Defined:
  - A header beat precedes the data beats: out_data = count zero-extended or truncated to DATA_W, taken from the latched count.
  - Extra state HEADER, entered from IDLE on start.
  - For samples=0 the header is still sent, with out_last=1, and done pulses after its handshake.
  - Otherwise: HEADER handshake -> FETCH with index=0.
- Undefined: no header; samples=0 produces no beats, as above.

Decomposition:
- Shared package / iob_ila.vh:
  - State encodings: IDLE=0, FETCH=1, CAPTURE=2, SEND=3, HEADER=4; 3-bit state.
  - Localparam for the ila_core read latency (1).
- Sub-module: none required. The FSM and a single output register stage fit in one module.
- The stream output register may later be split out as a reusable `iob_skid_reg` if throughput must reach 1 beat/cycle.

Test Plan:
- Basic dump, header off:
  - Stimulus: model ila_core with samples=2, buffer {0x12,0x21}, out_ready=1, pulse start.
  - Required: beats 0x12 then 0x21; out_last only on 0x21; done one cycle after the second handshake; busy low afterwards.
- Backpressure:
  - Stimulus: samples=3, buffer {0xA0,0xA1,0xA2}; out_ready low for 5 cycles on each beat.
  - Required: out_data/out_valid stable while stalled; exactly 3 beats in order; no duplicates.
- Empty buffer:
  - Stimulus: samples=0, start.
  - Required: no out_valid; done pulse; with ILA_READER_HEADER_EN, a single beat 0x00 with out_last=1.
- Abort:
  - Stimulus: samples=4, abort asserted in the second SEND while out_ready=1.
  - Required: only one beat accepted; out_valid=0 next cycle; done pulse; a restart dumps all 4 beats from index 0.
- Reset and start-while-busy:
  - Stimulus: rst asserted mid-dump; start re-pulsed while busy.
  - Required: all outputs reach reset values at the next edge; start while busy does not restart the dump or alter index.
- Large count with header:
  - Stimulus: ILA_READER_HEADER_EN defined, samples=0xFF.
  - Required: header beat 0xFF, then 255 data beats for index 0..0xFE; out_last on the index 0xFE beat.
